alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req0_valid  input  1  port 0 has an operation pending.
REQ-005 o_req0_ready  output  1  port 0 operation accepted this cycle.
REQ-006 i_req0_opsel / i_req0_sub / i_req0_unsigned / i_req0_arith  input  3/1/1/1  port 0 ALU controls, same encoding as the core ALU.
REQ-007 i_req0_op1 / i_req0_op2  input  32/32  port 0 operands.
REQ-008 i_req1_* / o_req1_ready  same widths and meanings as REQ-004 to REQ-007, for port 1.
REQ-009 o_rsp_valid  output  1  response register holds a result.
REQ-010 i_rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 o_rsp_id  output  1  port that issued the held result.
REQ-012 o_rsp_result / o_rsp_eq / o_rsp_slt  output  32/1/1  registered ALU outputs.

Function
REQ-013 Instantiate exactly one core ALU; drive its inputs from a combinational mux selected by the current grant.
REQ-014 Use a two-state output FSM: EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1).
REQ-015 Define can_accept = EMPTY or (FULL and i_rsp_ready).
REQ-016 Issue at most one grant per cycle, only when can_accept=1.
REQ-017 Set o_reqN_ready=1 only in a cycle where port N is granted; a transfer occurs when valid and ready are both 1.
REQ-018 Do not make o_reqN_ready depend on i_reqN_valid of the same port other than through the grant.
REQ-019 i_rsp_ready may feed o_reqN_ready combinationally.
REQ-020 Arbitration, RR_EN=1:
- one port valid: grant that port.
- both ports valid: grant the port not granted last.
- last-grant pointer updates only on a transfer.
REQ-021 Arbitration, RR_EN=0: both valid grants port 0; port 1 is granted only when port 0 is not valid.
REQ-022 Latency is one cycle: an operation transferred at edge N has its result, eq, slt and id in the response registers with o_rsp_valid=1 after edge N.
REQ-023 FSM transitions:
- EMPTY -> FULL on transfer.
- FULL -> EMPTY when i_rsp_ready=1 and there is no transfer.
- FULL stays FULL on simultaneous drain and transfer; registers load the new result.
- FULL with i_rsp_ready=0 holds all response outputs stable.
REQ-024 Port inputs are sampled only in the transfer cycle; later changes to an accepted port's inputs do not affect the held result.
REQ-025 Arithmetic matches the core ALU bit-exactly:
- 32-bit wrap-around with carry dropped.
- shift amount is op2[4:0].
- opsel 010 and 011 give identical results.
REQ-026 A request that is valid but not granted receives no ready and is not lost; the requester holds it until granted.
REQ-027 Fairness, RR_EN=1: with both ports continuously valid and i_rsp_ready=1, grants alternate 0,1,0,1.

Reset
REQ-028 With i_rst=1 at an edge, clear o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_eq and o_rsp_slt to 0, and set the FSM to EMPTY.
REQ-029 With i_rst=1 at an edge, set the last-grant pointer to 1, so port 0 wins the first contention.
REQ-030 While i_rst=1, drive o_req0_ready=o_req1_ready=0; an in-flight held result is discarded.
REQ-031 Grants may be issued in the first cycle after i_rst deasserts.

Verification
REQ-032 Single add: port 0 sends opsel=000, op1=5, op2=7, i_rsp_ready=1 -> next cycle o_rsp_valid=1, id=0, result=12, eq=0, slt=1.
REQ-033 Contention: both ports valid after reset, RR_EN=1, port 0 sub 3-5, port 1 sra 0x80000000 by 4 -> cycle 1: id=0, result=0xFFFFFFFE; cycle 2: id=1, result=0xF8000000.
REQ-034 Backpressure: i_rsp_ready=0 for 3 cycles with both ports valid -> no ready asserted after the first transfer, response outputs stable, no request dropped; on release, the queued port completes.
REQ-035 Fixed priority: RR_EN=0, both ports valid for 4 cycles -> port 0 granted in all 4 cycles, port 1 never.
REQ-036 Reset mid-operation: assert i_rst while FULL, holding result 0x1234 -> next cycle o_rsp_valid=0, result=0; first contention afterwards goes to port 0.
REQ-037 Boundaries: sltu 0xFFFFFFFF vs 1 gives 0, slt gives 1; add 0xFFFFFFFF+1 gives 0 with eq=0; sll by op2=33 shifts by 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one combinational ALU core. Each cycle at most one
// requester is granted. Its operation goes through the core, and the result is
// captured in a single-entry response register. The response register is a
// two-state EMPTY/FULL holding stage with a valid/ready handshake toward the
// consumer.
//
// Parameters
//   RR_EN            1 = round-robin between the ports, 0 = port 0 always wins
//
// Ports
//   i_clk            clock; all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_reqN_valid     port N has an operation pending
//   o_reqN_ready     port N is granted this cycle (transfer when valid&ready)
//   i_reqN_opsel     ALU operation select (see alu_core)
//   i_reqN_sub       subtract instead of add (opsel 000)
//   i_reqN_unsigned  unsigned compare for slt / set-less-than result
//   i_reqN_arith     arithmetic instead of logical right shift (opsel 101)
//   i_reqN_op1/op2   32-bit operands
//   o_rsp_valid      response register holds a result
//   i_rsp_ready      consumer takes the response this cycle
//   o_rsp_id         port that issued the held result
//   o_rsp_result     registered ALU result
//   o_rsp_eq         registered op1 == op2
//   o_rsp_slt        registered op1 < op2 (signed or unsigned per request)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_core
//
// Purely combinational 32-bit ALU.
//
// Opsel encoding
//   000  add / sub (sub=1)
//   001  shift left logical
//   010  set-less-than
//   011  set-less-than (same as 010)
//   100  xor
//   101  shift right (logical, or arithmetic when arith=1)
//   110  or
//   111  and
//
// Shift amount is op2[4:0]. Add/sub wrap at 32 bits. The eq and slt flags are
// always produced from the operands, whatever the opsel.
// ---------------------------------------------------------------------------
module alu_core (
  input  logic [2:0]  opsel,
  input  logic        sub,
  input  logic        unsigned_cmp,
  input  logic        arith,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result,
  output logic        eq,
  output logic        slt
);

  logic [4:0]  shamt;
  logic        less;
  logic [31:0] shr;

  // Compare flags and the shared right-shift result
  always_comb begin
    shamt = op2[4:0];
    eq    = (op1 == op2);
    if (unsigned_cmp) begin
      less = (op1 < op2);
    end else begin
      less = ($signed(op1) < $signed(op2));
    end
    slt = less;
    if (arith) begin
      shr = $unsigned($signed(op1) >>> shamt);
    end else begin
      shr = op1 >> shamt;
    end
  end

  // Result select
  always_comb begin
    result = 32'd0;
    case (opsel)
      3'b000:  result = sub ? (op1 - op2) : (op1 + op2);
      3'b001:  result = op1 << shamt;
      3'b010,
      3'b011:  result = {31'd0, less};
      3'b100:  result = op1 ^ op2;
      3'b101:  result = shr;
      3'b110:  result = op1 | op2;
      3'b111:  result = op1 & op2;
      default: result = 32'd0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [2:0]  i_req0_opsel,
  input  logic        i_req0_sub,
  input  logic        i_req0_unsigned,
  input  logic        i_req0_arith,
  input  logic [31:0] i_req0_op1,
  input  logic [31:0] i_req0_op2,

  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [2:0]  i_req1_opsel,
  input  logic        i_req1_sub,
  input  logic        i_req1_unsigned,
  input  logic        i_req1_arith,
  input  logic [31:0] i_req1_op1,
  input  logic [31:0] i_req1_op2,

  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_eq,
  output logic        o_rsp_slt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_eq_q, rsp_eq_d;
  logic        rsp_slt_q, rsp_slt_d;

  logic        can_accept;
  logic        gnt_any;
  logic        gnt_sel;
  logic        transfer;

  logic [2:0]  alu_opsel;
  logic        alu_sub;
  logic        alu_unsigned;
  logic        alu_arith;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_eq;
  logic        alu_slt;

  // Grant selection.
  // gnt_sel names the winning port. A grant is only issued when the response
  // stage can take the result this cycle, either because it is empty or
  // because the consumer is draining it. The granted port is always a valid
  // one, so any grant is a transfer.
  always_comb begin
    can_accept = (state_q == EMPTY) || i_rsp_ready;
    if (i_req0_valid && i_req1_valid) begin
      gnt_sel = (RR_EN != 0) ? ~last_q : 1'b0;
    end else begin
      gnt_sel = ~i_req0_valid;
    end
    gnt_any      = !i_rst && can_accept && (i_req0_valid || i_req1_valid);
    o_req0_ready = gnt_any && !gnt_sel;
    o_req1_ready = gnt_any && gnt_sel;
    transfer     = gnt_any;
  end

  // Operand mux in front of the single shared ALU
  always_comb begin
    if (gnt_sel) begin
      alu_opsel    = i_req1_opsel;
      alu_sub      = i_req1_sub;
      alu_unsigned = i_req1_unsigned;
      alu_arith    = i_req1_arith;
      alu_op1      = i_req1_op1;
      alu_op2      = i_req1_op2;
    end else begin
      alu_opsel    = i_req0_opsel;
      alu_sub      = i_req0_sub;
      alu_unsigned = i_req0_unsigned;
      alu_arith    = i_req0_arith;
      alu_op1      = i_req0_op1;
      alu_op2      = i_req0_op2;
    end
  end

  alu_core u_alu (
    .opsel        (alu_opsel),
    .sub          (alu_sub),
    .unsigned_cmp (alu_unsigned),
    .arith        (alu_arith),
    .op1          (alu_op1),
    .op2          (alu_op2),
    .result       (alu_result),
    .eq           (alu_eq),
    .slt          (alu_slt)
  );

  // Next state of the response stage and the round-robin pointer.
  // On a drain with a simultaneous transfer, the stage stays FULL and takes
  // the new result. Without a transfer, every response register holds.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_slt_d    = rsp_slt_q;

    case (state_q)
      EMPTY: begin
        if (transfer) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (!transfer && i_rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (transfer) begin
      last_d       = gnt_sel;
      rsp_id_d     = gnt_sel;
      rsp_result_d = alu_result;
      rsp_eq_d     = alu_eq;
      rsp_slt_d    = alu_slt;
    end
  end

  // State registers.
  // Reset leaves the pointer at port 1, so port 0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= EMPTY;
      last_q       <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_eq_q     <= 1'b0;
      rsp_slt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_slt_q    <= rsp_slt_d;
    end
  end

  assign o_rsp_valid  = (state_q == FULL);
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_eq     = rsp_eq_q;
  assign o_rsp_slt    = rsp_slt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives two arbiters from the same stimulus. One arbiter uses round-robin
// (RR_EN=1) and the other uses fixed priority (RR_EN=0).
//
// A behavioural model per instance predicts the grants and the held response.
// Every negative edge compares both instances against it. Directed
// hand-computed checks pin the main scenarios.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  typedef struct {
    bit          valid;
    logic [2:0]  opsel;
    bit          sub;
    bit          uns;
    bit          arith;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rsp_ready;
  req_t        p0, p1;

  logic [1:0]  rdy0, rdy1, rv, rid, req_eq, rslt;
  logic [31:0] rres [2];

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = round-robin instance, index 1 = fixed priority
  bit          m_init = 1'b0;
  bit          m_valid [2];
  bit          m_id    [2];
  logic [31:0] m_res   [2];
  bit          m_eq    [2];
  bit          m_slt   [2];
  bit          m_last  [2];

  always #5 i_clk = ~i_clk;

  alu_arbiter #(.RR_EN(1)) dut_rr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(p0.valid), .o_req0_ready(rdy0[0]), .i_req0_opsel(p0.opsel),
    .i_req0_sub(p0.sub), .i_req0_unsigned(p0.uns), .i_req0_arith(p0.arith),
    .i_req0_op1(p0.a), .i_req0_op2(p0.b),
    .i_req1_valid(p1.valid), .o_req1_ready(rdy1[0]), .i_req1_opsel(p1.opsel),
    .i_req1_sub(p1.sub), .i_req1_unsigned(p1.uns), .i_req1_arith(p1.arith),
    .i_req1_op1(p1.a), .i_req1_op2(p1.b),
    .o_rsp_valid(rv[0]), .i_rsp_ready(i_rsp_ready), .o_rsp_id(rid[0]),
    .o_rsp_result(rres[0]), .o_rsp_eq(req_eq[0]), .o_rsp_slt(rslt[0])
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(p0.valid), .o_req0_ready(rdy0[1]), .i_req0_opsel(p0.opsel),
    .i_req0_sub(p0.sub), .i_req0_unsigned(p0.uns), .i_req0_arith(p0.arith),
    .i_req0_op1(p0.a), .i_req0_op2(p0.b),
    .i_req1_valid(p1.valid), .o_req1_ready(rdy1[1]), .i_req1_opsel(p1.opsel),
    .i_req1_sub(p1.sub), .i_req1_unsigned(p1.uns), .i_req1_arith(p1.arith),
    .i_req1_op1(p1.a), .i_req1_op2(p1.b),
    .o_rsp_valid(rv[1]), .i_rsp_ready(i_rsp_ready), .o_rsp_id(rid[1]),
    .o_rsp_result(rres[1]), .o_rsp_eq(req_eq[1]), .o_rsp_slt(rslt[1])
  );

  // Compare helper shared by the model checker and the directed checks
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [2:0] opsel, input bit sub,
                              input bit uns, input bit arith,
                              input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.valid = 1'b1;
    r.opsel = opsel;
    r.sub   = sub;
    r.uns   = uns;
    r.arith = arith;
    r.a     = a;
    r.b     = b;
    return r;
  endfunction

  function automatic req_t idle();
    req_t r;
    r = mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    r.valid = 1'b0;
    return r;
  endfunction

  // Reference arithmetic: {slt, eq, result}
  function automatic logic [33:0] aluModel(input req_t r);
    logic [31:0] res;
    bit          lt;
    int          sh;
    sh  = int'(r.b % 32);
    lt  = r.uns ? (r.a < r.b) : ($signed(r.a) < $signed(r.b));
    res = 32'd0;
    case (r.opsel)
      3'd0:       res = r.sub ? r.a - r.b : r.a + r.b;
      3'd1:       res = r.a << sh;
      3'd2, 3'd3: res = lt ? 32'd1 : 32'd0;
      3'd4:       res = r.a ^ r.b;
      3'd5:       res = r.arith ? $unsigned($signed(r.a) >>> sh) : r.a >> sh;
      3'd6:       res = r.a | r.b;
      default:    res = r.a & r.b;
    endcase
    return {lt, (r.a == r.b), res};
  endfunction

  // Which port the instance must grant this cycle (-1 = none)
  function automatic int expGrant(input int k);
    if (i_rst) return -1;
    if (m_valid[k] && !i_rsp_ready) return -1;
    if (p0.valid && p1.valid) return (k == 0) ? (m_last[k] ? 0 : 1) : 0;
    if (p0.valid) return 0;
    if (p1.valid) return 1;
    return -1;
  endfunction

  // Model update on each rising edge
  always @(posedge i_clk) begin
    for (int k = 0; k < 2; k++) begin
      int          g;
      logic [33:0] o;
      if (i_rst) begin
        m_valid[k] = 1'b0;
        m_id[k]    = 1'b0;
        m_res[k]   = 32'd0;
        m_eq[k]    = 1'b0;
        m_slt[k]   = 1'b0;
        m_last[k]  = 1'b1;
      end else begin
        g = expGrant(k);
        if (g >= 0) begin
          o          = aluModel(g == 0 ? p0 : p1);
          m_valid[k] = 1'b1;
          m_id[k]    = (g == 1);
          m_res[k]   = o[31:0];
          m_eq[k]    = o[32];
          m_slt[k]   = o[33];
          m_last[k]  = (g == 1);
        end else if (m_valid[k] && i_rsp_ready) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    if (i_rst) m_init = 1'b1;
  end

  // Continuous comparison against the model, away from the rising edge
  always @(negedge i_clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        int g;
        g = expGrant(k);
        checkOutput($sformatf("model_ready0[%0d]", k), 32'(rdy0[k]), 32'(g == 0));
        checkOutput($sformatf("model_ready1[%0d]", k), 32'(rdy1[k]), 32'(g == 1));
        checkOutput($sformatf("model_valid[%0d]", k), 32'(rv[k]), 32'(m_valid[k]));
        if (m_valid[k]) begin
          checkOutput($sformatf("model_id[%0d]", k), 32'(rid[k]), 32'(m_id[k]));
          checkOutput($sformatf("model_result[%0d]", k), rres[k], m_res[k]);
          checkOutput($sformatf("model_eq[%0d]", k), 32'(req_eq[k]), 32'(m_eq[k]));
          checkOutput($sformatf("model_slt[%0d]", k), 32'(rslt[k]), 32'(m_slt[k]));
        end
      end
    end
  end

  task automatic drive(input req_t r0, input req_t r1, input bit rdy, input bit rst);
    p0          = r0;
    p1          = r1;
    i_rsp_ready = rdy;
    i_rst       = rst;
  endtask

  // New inputs are applied just after a rising edge
  task automatic applyStimulus(input req_t r0, input req_t r1, input bit rdy,
                               input bit rst);
    @(posedge i_clk);
    #1;
    drive(r0, r1, rdy, rst);
  endtask

  // One port-0 operation with a free consumer, then check the response
  task automatic runSingle(input string name, input req_t r,
                           input logic [31:0] res, input bit eq, input bit slt);
    applyStimulus(r, idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput({name, "_ready0"}, 32'(rdy0[0]), 32'd1);
    applyStimulus(idle(), idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput({name, "_valid"}, 32'(rv[0]), 32'd1);
    checkOutput({name, "_id"}, 32'(rid[0]), 32'd0);
    checkOutput({name, "_result"}, rres[0], res);
    checkOutput({name, "_eq"}, 32'(req_eq[0]), 32'(eq));
    checkOutput({name, "_slt"}, 32'(rslt[0]), 32'(slt));
  endtask

  initial begin
    req_t sub35, sra4, bp_a, bp_b, bp_x;

    // Reset with a request pending; ready must stay low
    drive(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1), idle(), 1'b1, 1'b1);
    applyStimulus(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1), idle(), 1'b1, 1'b1);
    @(negedge i_clk);
    checkOutput("rst_ready0", 32'(rdy0[0]), 32'd0);
    checkOutput("rst_ready1", 32'(rdy1[0]), 32'd0);
    checkOutput("rst_valid", 32'(rv[0]), 32'd0);
    checkOutput("rst_result", rres[0], 32'd0);

    // Single add, granted in the first cycle out of reset
    runSingle("add5_7", mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7), 32'd12, 1'b0, 1'b1);

    // Contention straight after reset: port 0 first, then port 1
    sub35 = mk(3'b000, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    sra4  = mk(3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
    applyStimulus(idle(), idle(), 1'b1, 1'b1);
    applyStimulus(sub35, sra4, 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("cont_ready0", 32'(rdy0[0]), 32'd1);
    checkOutput("cont_ready1", 32'(rdy1[0]), 32'd0);
    applyStimulus(idle(), sra4, 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("cont_c1_id", 32'(rid[0]), 32'd0);
    checkOutput("cont_c1_result", rres[0], 32'hFFFF_FFFE);
    checkOutput("cont_c1_ready1", 32'(rdy1[0]), 32'd1);
    applyStimulus(idle(), idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("cont_c2_id", 32'(rid[0]), 32'd1);
    checkOutput("cont_c2_result", rres[0], 32'hF800_0000);

    // Backpressure: port 0 transfers, then three stalled cycles.
    // Port 0's inputs change after it is accepted.
    bp_a = mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
    bp_x = mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd100, 32'd200);
    bp_b = mk(3'b100, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
    applyStimulus(bp_a, bp_b, 1'b0, 1'b0);
    @(negedge i_clk);
    checkOutput("bp_first_ready0", 32'(rdy0[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bp_x, bp_b, 1'b0, 1'b0);
      @(negedge i_clk);
      checkOutput($sformatf("bp_stall%0d_ready0", i), 32'(rdy0[0]), 32'd0);
      checkOutput($sformatf("bp_stall%0d_ready1", i), 32'(rdy1[0]), 32'd0);
      checkOutput($sformatf("bp_stall%0d_valid", i), 32'(rv[0]), 32'd1);
      checkOutput($sformatf("bp_stall%0d_result", i), rres[0], 32'd30);
    end
    applyStimulus(bp_x, bp_b, 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("bp_release_ready1", 32'(rdy1[0]), 32'd1);
    checkOutput("bp_release_ready0", 32'(rdy0[0]), 32'd0);
    applyStimulus(idle(), idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("bp_done_id", 32'(rid[0]), 32'd1);
    checkOutput("bp_done_result", rres[0], 32'h0000_FF00);

    // Fixed priority: port 0 wins every cycle on the RR_EN=0 instance
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2),
                    mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4), 1'b1, 1'b0);
      @(negedge i_clk);
      checkOutput($sformatf("fp%0d_ready0", i), 32'(rdy0[1]), 32'd1);
      checkOutput($sformatf("fp%0d_ready1", i), 32'(rdy1[1]), 32'd0);
    end
    applyStimulus(idle(), idle(), 1'b1, 1'b0);

    // Reset while FULL holding 0x1234
    applyStimulus(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0234), idle(), 1'b0, 1'b0);
    applyStimulus(idle(), idle(), 1'b0, 1'b0);
    @(negedge i_clk);
    checkOutput("mid_full_result", rres[0], 32'h0000_1234);
    applyStimulus(sub35, sra4, 1'b0, 1'b1);
    @(negedge i_clk);
    checkOutput("mid_rst_ready0", 32'(rdy0[0]), 32'd0);
    checkOutput("mid_rst_ready1", 32'(rdy1[0]), 32'd0);
    applyStimulus(sub35, sra4, 1'b0, 1'b0);
    @(negedge i_clk);
    checkOutput("mid_after_valid", 32'(rv[0]), 32'd0);
    checkOutput("mid_after_result", rres[0], 32'd0);
    checkOutput("mid_after_ready0", 32'(rdy0[0]), 32'd1);
    checkOutput("mid_after_ready1", 32'(rdy1[0]), 32'd0);
    applyStimulus(idle(), idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("mid_after_id", 32'(rid[0]), 32'd0);

    // Boundary operations
    runSingle("sltu", mk(3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0, 1'b0, 1'b0);
    runSingle("slt", mk(3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd1, 1'b0, 1'b1);
    runSingle("addwrap", mk(3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0, 1'b0, 1'b1);
    runSingle("sll33", mk(3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'd33), 32'd2, 1'b0, 1'b1);

    applyStimulus(idle(), idle(), 1'b1, 1'b0);
    @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
